// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
//
// Arbitrates pipeline exceptions, MRET and (optionally) the external
// interrupt. It then sequences the trap: one FLUSH cycle, one REDIRECT
// cycle and one WAIT cycle before events are accepted again.
//
// Configuration macro:
//   TRAP_INTERRUPT_EN - when defined, a sticky pending-interrupt latch is
//                       built. It sets on `interrupt` and is taken in IDLE
//                       when `mstatusMIE`=1 and no other event is present.
//                       When undefined, `interrupt` and `mstatusMIE` are
//                       ignored and `mcauseInterrupt` is always 0.
//
// Ports:
//   clock, reset                  rising-edge clock, sync active-high reset
//   decodeExceptionValid/Cause    decode/execute-stage exception
//   executeExceptionValid/Cause   execute/memory-stage exception
//   memoryExceptionValid/Cause    memory/writeback-stage exception
//   mretValid                     MRET resolving this cycle
//   interrupt, mstatusMIE         interrupt line (level) and global enable
//   trapVector, mepc              MTVEC / MEPC from the CSR file
//   controlReset                  CSR capture pulse (acceptance cycle only)
//   mcause, mcauseInterrupt       cause of the trap being accepted
//   flush                         kill all in-flight stages (FLUSH state)
//   redirectValid, redirectPC     fetch redirect (REDIRECT state)
//   busy                          FSM not in IDLE
//   debug_state                   current FSM state encoding
//
// Handshake: events are single-cycle qualifiers with no ready signal. An
// event is consumed only in the cycle it is presented while the FSM is in
// IDLE; anything presented in FLUSH, REDIRECT or WAIT is dropped. The
// pending-interrupt latch is the only exception to that rule.
// ---------------------------------------------------------------------------
module trap_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        decodeExceptionValid,
  input  logic [3:0]  decodeCause,
  input  logic        executeExceptionValid,
  input  logic [3:0]  executeCause,
  input  logic        memoryExceptionValid,
  input  logic [3:0]  memoryCause,
  input  logic        mretValid,
  input  logic        interrupt,
  input  logic        mstatusMIE,
  input  logic [31:0] trapVector,
  input  logic [31:0] mepc,
  output logic        controlReset,
  output logic [3:0]  mcause,
  output logic        mcauseInterrupt,
  output logic        flush,
  output logic        redirectValid,
  output logic [31:0] redirectPC,
  output logic        busy,
  output logic [1:0]  debug_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2,
    WAIT     = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] target;

  logic        accept_exc;
  logic        accept_mret;
  logic        accept_irq;
  logic [3:0]  sel_cause;
  logic        irq_take;

  // The vector is word-aligned on redirect, so its mode bits are dropped.
  logic unused_vec_bits;
  assign unused_vec_bits = ^trapVector[1:0];

`ifdef TRAP_INTERRUPT_EN
  logic irq_pending;

  assign irq_take = irq_pending & mstatusMIE;

  // A new assertion wins over the clear, so a line still held high when it
  // is taken gets taken again after the sequence finishes.
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_pending <= 1'b0;
    end else if (interrupt) begin
      irq_pending <= 1'b1;
    end else if (accept_irq) begin
      irq_pending <= 1'b0;
    end
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = interrupt ^ mstatusMIE;
  assign irq_take          = 1'b0;
`endif

  // Priority arbitration; only active in IDLE. Reset suppresses acceptance
  // so no capture pulse escapes while the controller is being cleared.
  always_comb begin
    accept_exc  = 1'b0;
    accept_mret = 1'b0;
    accept_irq  = 1'b0;
    sel_cause   = 4'h0;
    if (state == IDLE && !reset) begin
      if (memoryExceptionValid) begin
        accept_exc = 1'b1;
        sel_cause  = memoryCause;
      end else if (executeExceptionValid) begin
        accept_exc = 1'b1;
        sel_cause  = executeCause;
      end else if (decodeExceptionValid) begin
        accept_exc = 1'b1;
        sel_cause  = decodeCause;
      end else if (mretValid) begin
        accept_mret = 1'b1;
      end else if (irq_take) begin
        accept_irq = 1'b1;
        sel_cause  = 4'hB;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      target <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_exc || accept_irq) begin
            state  <= FLUSH;
            target <= {trapVector[31:2], 2'b00};
          end else if (accept_mret) begin
            state  <= FLUSH;
            target <= mepc;
          end
        end
        FLUSH:    state <= REDIRECT;
        REDIRECT: state <= WAIT;
        WAIT:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign controlReset    = accept_exc | accept_irq;
  assign mcause          = sel_cause;
  assign mcauseInterrupt = accept_irq;
  assign flush           = (state == FLUSH);
  assign redirectValid   = (state == REDIRECT);
  assign redirectPC      = redirectValid ? target : 32'h0;
  assign busy            = (state != IDLE);
  assign debug_state     = state;

endmodule

// File: tb/tb_trap_controller.sv
// ---------------------------------------------------------------------------
// tb_trap_controller
//
// Directed bench for trap_controller. Inputs change just after the falling
// edge and outputs are sampled 1 time unit later, well away from the rising
// edge. Every output is packed into one vector per cycle:
// {controlReset, mcauseInterrupt, flush, redirectValid, busy, mcause,
// redirectPC}. That vector is compared with a hand-computed value.
// ---------------------------------------------------------------------------
module tb_trap_controller;

  logic        clock;
  logic        reset;
  logic        decodeExceptionValid;
  logic [3:0]  decodeCause;
  logic        executeExceptionValid;
  logic [3:0]  executeCause;
  logic        memoryExceptionValid;
  logic [3:0]  memoryCause;
  logic        mretValid;
  logic        interrupt;
  logic        mstatusMIE;
  logic [31:0] trapVector;
  logic [31:0] mepc;
  logic        controlReset;
  logic [3:0]  mcause;
  logic        mcauseInterrupt;
  logic        flush;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic        busy;
  logic [1:0]  debug_state;

  int compared = 0;
  int mismatched = 0;

  trap_controller dut (
    .clock                 (clock),
    .reset                 (reset),
    .decodeExceptionValid  (decodeExceptionValid),
    .decodeCause           (decodeCause),
    .executeExceptionValid (executeExceptionValid),
    .executeCause          (executeCause),
    .memoryExceptionValid  (memoryExceptionValid),
    .memoryCause           (memoryCause),
    .mretValid             (mretValid),
    .interrupt             (interrupt),
    .mstatusMIE            (mstatusMIE),
    .trapVector            (trapVector),
    .mepc                  (mepc),
    .controlReset          (controlReset),
    .mcause                (mcause),
    .mcauseInterrupt       (mcauseInterrupt),
    .flush                 (flush),
    .redirectValid         (redirectValid),
    .redirectPC            (redirectPC),
    .busy                  (busy),
    .debug_state           (debug_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [40:0] outs();
    return {controlReset, mcauseInterrupt, flush, redirectValid, busy,
            mcause, redirectPC};
  endfunction

  function automatic logic [40:0] pk(input logic cr, input logic mi,
                                     input logic fl, input logic rv,
                                     input logic bs, input logic [3:0] mc,
                                     input logic [31:0] pc);
    return {cr, mi, fl, rv, bs, mc, pc};
  endfunction

  // Driver tasks
  task automatic clear_events();
    decodeExceptionValid  = 1'b0;
    decodeCause           = 4'h0;
    executeExceptionValid = 1'b0;
    executeCause          = 4'h0;
    memoryExceptionValid  = 1'b0;
    memoryCause           = 4'h0;
    mretValid             = 1'b0;
    interrupt             = 1'b0;
  endtask

  // Advance to just after the next falling edge (input drive point).
  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic test_reset();
    clear_events();
    mstatusMIE = 1'b0;
    trapVector = 32'h0;
    mepc       = 32'h0;
    reset      = 1'b1;
    repeat (3) @(posedge clock);
    next_cycle();
    #1;
    compared++;
    if (outs() !== pk(0, 0, 0, 0, 0, 4'h0, 32'h0)) begin
      $display("FAIL reset_outputs: got %h expected %h", outs(),
               pk(0, 0, 0, 0, 0, 4'h0, 32'h0));
      mismatched++;
    end
    compared++;
    if (debug_state !== 2'd0) begin
      $display("FAIL reset_state: got %0d expected 0", debug_state);
      mismatched++;
    end
    reset = 1'b0;
  endtask

  task automatic test_decode_trap();
    logic [40:0] e[5];
    e[0] = pk(1, 0, 0, 0, 0, 4'h2, 32'h0);
    e[1] = pk(0, 0, 1, 0, 1, 4'h0, 32'h0);
    e[2] = pk(0, 0, 0, 1, 1, 4'h0, 32'h0000_0100);
    e[3] = pk(0, 0, 0, 0, 1, 4'h0, 32'h0);
    e[4] = pk(0, 0, 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      clear_events();
      if (i == 0) begin
        trapVector           = 32'h0000_0103;
        decodeExceptionValid = 1'b1;
        decodeCause          = 4'h2;
      end
      #1;
      compared++;
      if (outs() !== e[i]) begin
        $display("FAIL decode_trap c%0d: got %h expected %h", i, outs(), e[i]);
        mismatched++;
      end
    end
  endtask

  task automatic test_priority();
    logic [40:0] e[5];
    e[0] = pk(1, 0, 0, 0, 0, 4'h6, 32'h0);
    e[1] = pk(0, 0, 1, 0, 1, 4'h0, 32'h0);
    e[2] = pk(0, 0, 0, 1, 1, 4'h0, 32'h0000_1000);
    e[3] = pk(0, 0, 0, 0, 1, 4'h0, 32'h0);
    e[4] = pk(0, 0, 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      clear_events();
      // Held for two cycles: the copy in FLUSH must not pulse again.
      if (i < 2) begin
        trapVector            = 32'h0000_1003;
        memoryExceptionValid  = 1'b1;
        memoryCause           = 4'h6;
        executeExceptionValid = 1'b1;
        executeCause          = 4'h0;
        decodeExceptionValid  = 1'b1;
        decodeCause           = 4'hB;
      end
      #1;
      compared++;
      if (outs() !== e[i]) begin
        $display("FAIL priority c%0d: got %h expected %h", i, outs(), e[i]);
        mismatched++;
      end
    end
  endtask

  task automatic test_passthrough();
    logic [40:0] e[5];
    // Execute beats decode; cause 0 must still pulse controlReset.
    next_cycle();
    clear_events();
    executeExceptionValid = 1'b1;
    executeCause          = 4'h0;
    decodeExceptionValid  = 1'b1;
    decodeCause           = 4'h2;
    #1;
    compared++;
    if (outs() !== pk(1, 0, 0, 0, 0, 4'h0, 32'h0)) begin
      $display("FAIL exec_cause0: got %h expected %h", outs(),
               pk(1, 0, 0, 0, 0, 4'h0, 32'h0));
      mismatched++;
    end
    repeat (4) next_cycle();
    // Unlisted cause D on memory beats a simultaneous MRET; target is MTVEC.
    e[0] = pk(1, 0, 0, 0, 0, 4'hD, 32'h0);
    e[1] = pk(0, 0, 1, 0, 1, 4'h0, 32'h0);
    e[2] = pk(0, 0, 0, 1, 1, 4'h0, 32'h8000_0040);
    e[3] = pk(0, 0, 0, 0, 1, 4'h0, 32'h0);
    e[4] = pk(0, 0, 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) next_cycle();
      clear_events();
      if (i == 0) begin
        trapVector           = 32'h8000_0041;
        mepc                 = 32'h0000_5550;
        memoryExceptionValid = 1'b1;
        memoryCause          = 4'hD;
        mretValid            = 1'b1;
      end
      #1;
      compared++;
      if (outs() !== e[i]) begin
        $display("FAIL passthrough c%0d: got %h expected %h", i, outs(), e[i]);
        mismatched++;
      end
    end
  endtask

  task automatic test_mret();
    logic [40:0] e[5];
    e[0] = pk(0, 0, 0, 0, 0, 4'h0, 32'h0);
    e[1] = pk(0, 0, 1, 0, 1, 4'h0, 32'h0);
    e[2] = pk(0, 0, 0, 1, 1, 4'h0, 32'h0000_2040);
    e[3] = pk(0, 0, 0, 0, 1, 4'h0, 32'h0);
    e[4] = pk(0, 0, 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      clear_events();
      if (i == 0) begin
        trapVector = 32'h0000_0F03;
        mepc       = 32'h0000_2040;
        mretValid  = 1'b1;
      end
      #1;
      compared++;
      if (outs() !== e[i]) begin
        $display("FAIL mret c%0d: got %h expected %h", i, outs(), e[i]);
        mismatched++;
      end
    end
  endtask

  task automatic test_ignore_busy();
    logic [40:0] e[5];
    e[0] = pk(1, 0, 0, 0, 0, 4'h2, 32'h0);
    e[1] = pk(0, 0, 1, 0, 1, 4'h0, 32'h0);
    e[2] = pk(0, 0, 0, 1, 1, 4'h0, 32'h0000_0200);
    e[3] = pk(0, 0, 0, 0, 1, 4'h0, 32'h0);
    e[4] = pk(0, 0, 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      clear_events();
      trapVector = 32'h0000_0200;
      if (i == 0) begin
        decodeExceptionValid = 1'b1;
        decodeCause          = 4'h2;
      end else if (i == 1) begin
        decodeExceptionValid = 1'b1;
        decodeCause          = 4'h3;
      end
      #1;
      compared++;
      if (outs() !== e[i]) begin
        $display("FAIL ignore_busy c%0d: got %h expected %h", i, outs(), e[i]);
        mismatched++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [40:0] e[9];
    // Decode exception held continuously: taken again on IDLE re-entry.
    e[0] = pk(1, 0, 0, 0, 0, 4'hB, 32'h0);
    e[1] = pk(0, 0, 1, 0, 1, 4'h0, 32'h0);
    e[2] = pk(0, 0, 0, 1, 1, 4'h0, 32'h0000_0300);
    e[3] = pk(0, 0, 0, 0, 1, 4'h0, 32'h0);
    e[4] = pk(1, 0, 0, 0, 0, 4'hB, 32'h0);
    e[5] = pk(0, 0, 1, 0, 1, 4'h0, 32'h0);
    e[6] = pk(0, 0, 0, 1, 1, 4'h0, 32'h0000_0300);
    e[7] = pk(0, 0, 0, 0, 1, 4'h0, 32'h0);
    e[8] = pk(0, 0, 0, 0, 0, 4'h0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      clear_events();
      trapVector = 32'h0000_0302;
      if (i <= 4) begin
        decodeExceptionValid = 1'b1;
        decodeCause          = 4'hB;
      end
      #1;
      compared++;
      if (outs() !== e[i]) begin
        $display("FAIL back_to_back c%0d: got %h expected %h", i, outs(), e[i]);
        mismatched++;
      end
    end
  endtask

  task automatic test_reset_mid();
    next_cycle();
    clear_events();
    trapVector           = 32'h0000_0400;
    decodeExceptionValid = 1'b1;
    decodeCause          = 4'h2;
    next_cycle();
    clear_events();
    reset = 1'b1;
    #1;
    compared++;
    if (flush !== 1'b1) begin
      $display("FAIL reset_mid_flush: got %b expected 1", flush);
      mismatched++;
    end
    next_cycle();
    reset = 1'b0;
    #1;
    compared++;
    if (outs() !== pk(0, 0, 0, 0, 0, 4'h0, 32'h0)) begin
      $display("FAIL reset_mid_after: got %h expected %h", outs(),
               pk(0, 0, 0, 0, 0, 4'h0, 32'h0));
      mismatched++;
    end
    compared++;
    if (debug_state !== 2'd0) begin
      $display("FAIL reset_mid_state: got %0d expected 0", debug_state);
      mismatched++;
    end
    next_cycle();
    #1;
    compared++;
    if (outs() !== pk(0, 0, 0, 0, 0, 4'h0, 32'h0)) begin
      $display("FAIL reset_mid_idle: got %h expected %h", outs(),
               pk(0, 0, 0, 0, 0, 4'h0, 32'h0));
      mismatched++;
    end
  endtask

`ifdef TRAP_INTERRUPT_EN
  task automatic test_interrupt();
    logic [40:0] e[7];
    // Interrupt pulsed in FLUSH with MIE=1, taken on IDLE re-entry.
    e[0] = pk(1, 0, 0, 0, 0, 4'h2, 32'h0);
    e[1] = pk(0, 0, 1, 0, 1, 4'h0, 32'h0);
    e[2] = pk(0, 0, 0, 1, 1, 4'h0, 32'h0000_0500);
    e[3] = pk(0, 0, 0, 0, 1, 4'h0, 32'h0);
    e[4] = pk(1, 1, 0, 0, 0, 4'hB, 32'h0);
    e[5] = pk(0, 0, 1, 0, 1, 4'h0, 32'h0);
    e[6] = pk(0, 0, 0, 1, 1, 4'h0, 32'h0000_0500);
    mstatusMIE = 1'b1;
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      clear_events();
      trapVector = 32'h0000_0501;
      if (i == 0) begin
        decodeExceptionValid = 1'b1;
        decodeCause          = 4'h2;
      end else if (i == 1) begin
        interrupt = 1'b1;
      end
      #1;
      compared++;
      if (outs() !== e[i]) begin
        $display("FAIL irq_take c%0d: got %h expected %h", i, outs(), e[i]);
        mismatched++;
      end
    end
    repeat (2) next_cycle();
    // MIE=0: interrupt stays pending until the enable rises.
    mstatusMIE = 1'b0;
    interrupt  = 1'b1;
    next_cycle();
    interrupt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      compared++;
      if (outs() !== pk(0, 0, 0, 0, 0, 4'h0, 32'h0)) begin
        $display("FAIL irq_masked c%0d: got %h expected %h", i, outs(),
                 pk(0, 0, 0, 0, 0, 4'h0, 32'h0));
        mismatched++;
      end
      next_cycle();
    end
    mstatusMIE = 1'b1;
    #1;
    compared++;
    if (outs() !== pk(1, 1, 0, 0, 0, 4'hB, 32'h0)) begin
      $display("FAIL irq_unmasked: got %h expected %h", outs(),
               pk(1, 1, 0, 0, 0, 4'hB, 32'h0));
      mismatched++;
    end
    repeat (4) next_cycle();
    #1;
    compared++;
    if (outs() !== pk(0, 0, 0, 0, 0, 4'h0, 32'h0)) begin
      $display("FAIL irq_cleared: got %h expected %h", outs(),
               pk(0, 0, 0, 0, 0, 4'h0, 32'h0));
      mismatched++;
    end
    mstatusMIE = 1'b0;
  endtask
`else
  task automatic test_interrupt();
    // Without the latch the interrupt line has no effect at all.
    mstatusMIE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      clear_events();
      interrupt = (i < 2);
      #1;
      compared++;
      if (outs() !== pk(0, 0, 0, 0, 0, 4'h0, 32'h0)) begin
        $display("FAIL irq_ignored c%0d: got %h expected %h", i, outs(),
                 pk(0, 0, 0, 0, 0, 4'h0, 32'h0));
        mismatched++;
      end
    end
    mstatusMIE = 1'b0;
    interrupt  = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_decode_trap();
    test_priority();
    test_passthrough();
    test_mret();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_interrupt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
